// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmit path.
package fifo_uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, pulses bit_tick_o on wrap.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             bit_tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_tick_o = en_i && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign cnt_o      = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = bit_tick_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a byte FIFO, one 8N1/8N2 frame per pop.
// Optional parity bit enabled by defining FIFO_UART_PARITY_EN.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
`ifdef FIFO_UART_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] fifo_data_i,
  input  logic       fifo_empty_i,
  output logic       fifo_rd_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       tx_done_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 rd_q, rd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     cnt;
  logic                 bit_tick;
  logic                 cnt_en;

  assign cnt_en = (state_q == START) || (state_q == DATA) ||
                  (state_q == PARITY) || (state_q == STOP);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk        (clk),
    .rst        (rst),
    .en_i       (cnt_en),
    .clr_i      (!cnt_en),
    .cnt_o      (cnt),
    .bit_tick_o (bit_tick)
  );

  // Line outputs are registered from the current state, so the line trails
  // the FSM by one cycle; the popped word arrives in the first START cycle.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bit_idx_d = bit_idx_q;
    tx_d      = IDLE_LEVEL;
    rd_d      = 1'b0;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = !fifo_empty_i;
        if (!fifo_empty_i) begin
          rd_d    = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = START;
      START: begin
        tx_d = 1'b0;
        if (cnt == '0) data_d = fifo_data_i;
        if (bit_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        tx_d = data_q[bit_idx_q];
        if (bit_tick) begin
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
`ifdef FIFO_UART_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef FIFO_UART_PARITY_EN
      PARITY: begin
        tx_d = ^data_q ^ PARITY_ODD;
        if (bit_tick) state_d = STOP;
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (bit_tick) begin
          if (bit_idx_q == 3'(STOP_BITS - 1)) begin
            bit_idx_d = '0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        bit_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      bit_idx_q <= '0;
      tx_q      <= IDLE_LEVEL;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign fifo_rd_o = rd_q;
  assign tx_o      = tx_q;
  assign busy_o    = busy_q;
  assign tx_done_o = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (1 and 2 stop bits) fed by FIFO models.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  int in0 = 0, in1 = 0, out0 = 0, out1 = 0;
  int pop_err0 = 0, pop_err1 = 0;
  logic [7:0] fdata0 = 8'h00, fdata1 = 8'h00;
  logic fempty0, fempty1;
  logic [1:0] rd, tx, busy, done;

  assign fempty0 = (in0 == out0);
  assign fempty1 = (in1 == out1);

  // FIFO models: registered read data, valid the cycle after the pop
  always @(posedge clk) begin
    if (rd[0]) begin
      if (in0 == out0) pop_err0++;
      else begin
        fdata0 <= mem0[out0[7:0]];
        out0   <= out0 + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rd[1]) begin
      if (in1 == out1) pop_err1++;
      else begin
        fdata1 <= mem1[out1[7:0]];
        out1   <= out1 + 1;
      end
    end
  end

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .fifo_data_i(fdata0), .fifo_empty_i(fempty0),
    .fifo_rd_o(rd[0]), .tx_o(tx[0]), .busy_o(busy[0]), .tx_done_o(done[0])
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .fifo_data_i(fdata1), .fifo_empty_i(fempty1),
    .fifo_rd_o(rd[1]), .tx_o(tx[1]), .busy_o(busy[1]), .tx_done_o(done[1])
  );

  int compared = 0;
  int mismatched = 0;

  function automatic int frame_len(input int stop_bits);
    return (10 + stop_bits - 1 + PAR_BITS) * CPB;
  endfunction

  // Expected line level k cycles into the frame, from the frame layout.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    int per;
    per = k / CPB;
    if (per == 0) return 1'b0;
    if (per <= 8) return b[per-1];
    if (PAR_BITS == 1 && per == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic logic [7:0] fifo_word(input int sel, input int idx);
    return (sel == 0) ? mem0[idx[7:0]] : mem1[idx[7:0]];
  endfunction

  task automatic push(input int sel, input logic [7:0] b);
    if (sel == 0) begin mem0[in0[7:0]] = b; in0++; end
    else          begin mem1[in1[7:0]] = b; in1++; end
  endtask

  task automatic wait_pop(input int sel, output int p, output bit ok);
    ok = 1'b0;
    p  = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rd[sel]) begin
        p  = cyc;
        ok = 1'b1;
        break;
      end
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL wait_pop[%0d]: got no pop within 300 cycles, expected one", sel);
    end
  endtask

  task automatic check_frame(input int sel, input logic [7:0] b, input int stop_bits);
    int fl;
    logic [63:0] obs, expv;
    int done_at, done_cnt, busy_low;
    fl = frame_len(stop_bits);
    obs = '0; expv = '0; done_at = -1; done_cnt = 0; busy_low = 0;
    @(negedge clk);
    if (!busy[sel]) busy_low++;
    for (int k = 0; k < fl; k++) begin
      @(negedge clk);
      obs[k]  = tx[sel];
      expv[k] = exp_bit(b, k);
      if (done[sel]) begin done_cnt++; done_at = k; end
      if (!busy[sel]) busy_low++;
    end
    compared++;
    if (obs !== expv) begin
      mismatched++;
      $display("FAIL frame_line[%0d] byte %02h: got %h expected %h", sel, b, obs, expv);
    end
    compared++;
    if (done_cnt != 1 || done_at != fl - 1) begin
      mismatched++;
      $display("FAIL tx_done[%0d]: got %0d pulses last at %0d, expected 1 at %0d",
               sel, done_cnt, done_at, fl - 1);
    end
    compared++;
    if (busy_low != 0) begin
      mismatched++;
      $display("FAIL busy_frame[%0d]: got %0d low cycles, expected 0", sel, busy_low);
    end
  endtask

  task automatic stream(input int sel, input int stop_bits, input int first_idx, input int n);
    int p, prev;
    bit ok;
    prev = -1;
    for (int i = 0; i < n; i++) begin
      wait_pop(sel, p, ok);
      if (!ok) return;
      if (i > 0) begin
        compared++;
        if (p - prev != frame_len(stop_bits) + 2) begin
          mismatched++;
          $display("FAIL pop_spacing[%0d]: got %0d expected %0d", sel, p - prev,
                   frame_len(stop_bits) + 2);
        end
      end
      check_frame(sel, fifo_word(sel, first_idx + i), stop_bits);
      prev = p;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    compared++;
    if (tx !== 2'b11 || rd !== 2'b00 || busy !== 2'b00 || done !== 2'b00) begin
      mismatched++;
      $display("FAIL reset_state: got tx=%b rd=%b busy=%b done=%b, expected 11 00 00 00",
               tx, rd, busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int rd_cnt, tx_low, busy_cnt;
    rd_cnt = 0; tx_low = 0; busy_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (rd != 2'b00) rd_cnt++;
      if (tx != 2'b11) tx_low++;
      if (busy != 2'b00) busy_cnt++;
    end
    compared++;
    if (rd_cnt != 0) begin
      mismatched++; $display("FAIL idle_rd: got %0d pop cycles, expected 0", rd_cnt);
    end
    compared++;
    if (tx_low != 0) begin
      mismatched++; $display("FAIL idle_tx: got %0d low cycles, expected 0", tx_low);
    end
    compared++;
    if (busy_cnt != 0) begin
      mismatched++; $display("FAIL idle_busy: got %0d busy cycles, expected 0", busy_cnt);
    end
  endtask

  task automatic test_single();
    int idx, extra;
    idx = in0;
    push(0, 8'hA5);
    stream(0, 1, idx, 1);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd[0] || !tx[0] || busy[0]) extra++;
    end
    compared++;
    if (extra != 0) begin
      mismatched++; $display("FAIL single_after: got %0d active cycles, expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int idx0, idx1;
    idx0 = in0;
    push(0, 8'h00);
    push(0, 8'hFF);
    idx1 = in1;
    push(1, 8'h3C);
    push(1, 8'hC3);
    fork
      stream(0, 1, idx0, 2);
      stream(1, 2, idx1, 2);
    join
  endtask

  task automatic test_random();
    int idx0, idx1, n0, n1;
    idx0 = in0; idx1 = in1;
    n0 = $urandom_range(5, 3);
    n1 = $urandom_range(4, 2);
    for (int i = 0; i < n0; i++) push(0, 8'($urandom));
    for (int i = 0; i < n1; i++) push(1, 8'($urandom));
    fork
      stream(0, 1, idx0, n0);
      stream(1, 2, idx1, n1);
    join
  endtask

  task automatic test_reset_mid();
    int idx, p;
    bit ok;
    idx = in0;
    push(0, 8'h52);
    push(0, 8'hC3);
    wait_pop(0, p, ok);
    if (!ok) return;
    repeat (19) @(negedge clk);
    compared++;
    if (tx[0] !== 1'b0) begin
      mismatched++; $display("FAIL mid_bit3: got tx=%b expected 0", tx[0]);
    end
    rst = 1'b1;
    #1;
    compared++;
    if (tx[0] !== 1'b1 || rd[0] !== 1'b0 || busy[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset: got tx=%b rd=%b busy=%b, expected 1 0 0", tx[0], rd[0], busy[0]);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    compared++;
    if (out0 != idx + 1) begin
      mismatched++; $display("FAIL mid_pops: got %0d words popped, expected %0d", out0, idx + 1);
    end
    stream(0, 1, idx + 1, 1);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_random();
    test_reset_mid();
    repeat (5) @(negedge clk);
    compared++;
    if (pop_err0 != 0 || pop_err1 != 0) begin
      mismatched++;
      $display("FAIL pop_while_empty: got %0d/%0d, expected 0/0", pop_err0, pop_err1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
